alu_muldiv_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide companion to the combinational ALU. Implements the eight RV32M-style operations with an iterative radix-2 datapath.
- Uses valid/ready handshakes on both sides so the pipeline can stall on it.
- Sits beside the ALU in the execute stage. It reuses the ALU's 3-bit control-code style and its result/zero/negative flag outputs.

---
 rtl/alu_muldiv_seq_if.sv | 26 ++
 rtl/alu_muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Request/result handshake bundle for the sequential multiply/divide unit.
// The requester uses the master modport, the unit the slave modport.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_1;
  logic [WIDTH-1:0] i_2;
  logic [2:0]       i_ctrl;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_1;
  logic             o_zero;
  logic             o_neg;
  logic             o_valid;
  logic             i_ready;

  modport master (
    output i_1, i_2, i_ctrl, i_valid, i_ready,
    input  o_ready, o_1, o_zero, o_neg, o_valid
  );

  modport slave (
    input  i_1, i_2, i_ctrl, i_valid, i_ready,
    output o_ready, o_1, o_zero, o_neg, o_valid
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign correction when the result is taken.
//
// state | meaning
// IDLE  | o_ready=1, waiting for a request
// BUSY  | iterating while cnt>0, registering the corrected result when cnt==0
// DONE  | o_valid=1, result held until i_ready
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic             clk,
  input logic             rst,
  alu_muldiv_seq_if.slave bus
);
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] ITERS   = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [2:0]         op;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_res;
  logic               neg_rem;
  logic               special;

  logic               in_sgn_a, in_sgn_b, in_neg_a, in_neg_b, in_div, in_special;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b, in_spec_res;

  always_comb begin
    in_sgn_a    = (bus.i_ctrl != OP_MULHU) && (bus.i_ctrl != OP_DIVU) && (bus.i_ctrl != OP_REMU);
    in_sgn_b    = in_sgn_a && (bus.i_ctrl != OP_MULHSU);
    in_neg_a    = in_sgn_a & bus.i_1[WIDTH-1];
    in_neg_b    = in_sgn_b & bus.i_2[WIDTH-1];
    in_mag_a    = in_neg_a ? -bus.i_1 : bus.i_1;
    in_mag_b    = in_neg_b ? -bus.i_2 : bus.i_2;
    in_div      = bus.i_ctrl[2];
    in_special  = 1'b0;
    in_spec_res = '1;
    // Divide by zero and signed overflow bypass the iterations entirely
    if (in_div && (bus.i_2 == '0)) begin
      in_special  = 1'b1;
      in_spec_res = bus.i_ctrl[1] ? bus.i_1 : '1;
    end else if (((bus.i_ctrl == OP_DIV) || (bus.i_ctrl == OP_REM)) &&
                 (bus.i_1 == MIN_NEG) && (&bus.i_2)) begin
      in_special  = 1'b1;
      in_spec_res = bus.i_ctrl[1] ? '0 : bus.i_1;
    end
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    addend   = acc[0] ? opnd : '0;
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (!op[2])
      acc_step = {add_sum, acc[WIDTH-1:1]};
    else if (sub_diff[WIDTH])
      acc_step = {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_step = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, res;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    case (op)
      OP_MUL:                       res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:                       res = neg_res ? -quo : quo;
      OP_DIVU:                      res = quo;
      OP_REM:                       res = neg_rem ? -rem : rem;
      default:                      res = rem;
    endcase
    if (special) res = acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.o_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.o_1     <= '0;
      bus.o_zero  <= 1'b1;
      bus.o_neg   <= 1'b0;
      cnt         <= '0;
      op          <= OP_MUL;
      acc         <= '0;
      opnd        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      special     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            op          <= bus.i_ctrl;
            neg_res     <= in_neg_a ^ in_neg_b;
            neg_rem     <= in_neg_a;
            special     <= in_special;
            opnd        <= in_div ? in_mag_b : in_mag_a;
            // special results ride in acc so the finalise step is shared
            acc         <= {{WIDTH{1'b0}}, in_special ? in_spec_res :
                                           (in_div ? in_mag_a : in_mag_b)};
            cnt         <= in_special ? '0 : ITERS;
            bus.o_ready <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
          end else begin
            bus.o_1     <= res;
            bus.o_zero  <= (res == '0);
            bus.o_neg   <= res[WIDTH-1];
            bus.o_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            bus.o_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed and random operations on 32- and 8-bit
// instances, checked against an arithmetic reference model.
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(32)) b32 ();
  alu_muldiv_seq_if #(.WIDTH(8))  b8 ();

  alu_muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  alu_muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic longint ux(input logic [31:0] v, input int w);
    return longint'(v) & ((longint'(1) << w) - 1);
  endfunction

  function automatic longint sx(input logic [31:0] v, input int w);
    longint r;
    r = ux(v, w);
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic bit is_ovf(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int w);
    return ((c == 3'b100) || (c == 3'b110)) && (ux(a, w) == (longint'(1) << (w - 1))) && (sx(b, w) == -1);
  endfunction

  function automatic bit is_special(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int w);
    return c[2] && ((ux(b, w) == 0) || is_ovf(c, a, b, w));
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int w);
    longint sa, sb, ua, ub, r;
    longint unsigned pu;
    sa = sx(a, w); sb = sx(b, w); ua = ux(a, w); ub = ux(b, w);
    case (c)
      3'b000: r = sa * sb;
      3'b001: r = (sa * sb) >>> w;
      3'b010: r = (sa * ub) >>> w;
      3'b011: begin pu = $unsigned(ua * ub); r = $signed(pu >> w); end
      3'b100: r = (ub == 0) ? -1 : (is_ovf(c, a, b, w) ? sa : sa / sb);
      3'b101: r = (ub == 0) ? -1 : ua / ub;
      3'b110: r = (ub == 0) ? sa : (is_ovf(c, a, b, w) ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(ux(32'(r), w));
  endfunction

  task automatic drive(input bit w8, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic v);
    if (w8) begin
      b8.i_ctrl = c; b8.i_1 = a[7:0]; b8.i_2 = b[7:0]; b8.i_valid = v;
    end else begin
      b32.i_ctrl = c; b32.i_1 = a; b32.i_2 = b; b32.i_valid = v;
    end
  endtask

  task automatic set_iready(input bit w8, input logic r);
    if (w8) b8.i_ready = r; else b32.i_ready = r;
  endtask

  function automatic logic [31:0] res_of(input bit w8);
    return w8 ? {24'd0, b8.o_1} : b32.o_1;
  endfunction
  function automatic logic vld_of(input bit w8);
    return w8 ? b8.o_valid : b32.o_valid;
  endfunction
  function automatic logic rdy_of(input bit w8);
    return w8 ? b8.o_ready : b32.o_ready;
  endfunction
  function automatic logic zero_of(input bit w8);
    return w8 ? b8.o_zero : b32.o_zero;
  endfunction
  function automatic logic neg_of(input bit w8);
    return w8 ? b8.o_neg : b32.o_neg;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(15));
      4: return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  // One request from accept to release; hold = cycles of i_ready=0 in DONE
  task automatic do_op(input bit w8, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] exp_res;
    int w, lat;
    w = w8 ? 8 : 32;
    exp_res = ref_op(c, a, b, w);
    chk({tag, "/ready_idle"}, 32'(rdy_of(w8)), 32'd1);
    drive(w8, c, a, b, 1'b1);
    @(posedge clk); #1;
    drive(w8, 3'($urandom_range(7)), $urandom, $urandom, 1'b0);
    chk({tag, "/ready_busy"}, 32'(rdy_of(w8)), 32'd0);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (vld_of(w8)) break;
    end
    chk({tag, "/latency"}, 32'(lat), is_special(c, a, b, w) ? 32'd1 : 32'(w + 1));
    chk({tag, "/result"}, res_of(w8), exp_res);
    chk({tag, "/zero"}, 32'(zero_of(w8)), 32'(exp_res == 32'd0));
    chk({tag, "/neg"}, 32'(neg_of(w8)), 32'(exp_res[w-1]));
    for (int i = 0; i < hold; i++) begin
      drive(w8, 3'($urandom_range(7)), $urandom, $urandom, 1'b1);
      @(posedge clk); #1;
      chk({tag, "/hold_result"}, res_of(w8), exp_res);
      chk({tag, "/hold_valid"}, 32'(vld_of(w8)), 32'd1);
      chk({tag, "/hold_ready"}, 32'(rdy_of(w8)), 32'd0);
    end
    drive(w8, 3'd0, 32'd0, 32'd0, 1'b0);
    set_iready(w8, 1'b1);
    @(posedge clk); #1;
    set_iready(w8, 1'b0);
    chk({tag, "/valid_drop"}, 32'(vld_of(w8)), 32'd0);
    chk({tag, "/ready_back"}, 32'(rdy_of(w8)), 32'd1);
    chk({tag, "/result_kept"}, res_of(w8), exp_res);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    set_iready(1'b0, 1'b0);
    set_iready(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset/ready", 32'(b32.o_ready), 32'd1);
    chk("reset/valid", 32'(b32.o_valid), 32'd0);
    chk("reset/o_1", b32.o_1, 32'd0);
    chk("reset/zero", 32'(b32.o_zero), 32'd1);
    chk("reset/neg", 32'(b32.o_neg), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 0, "mul_neg");
    do_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    do_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_zero");
    do_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 0, "mulhsu");
    do_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    do_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 0, "rem_neg");
    do_op(1'b0, 3'b101, 32'd100, 32'd7, 0, "divu");
    do_op(1'b0, 3'b111, 32'd100, 32'd7, 0, "remu");
    do_op(1'b0, 3'b100, 32'd5, 32'd0, 0, "div_by0");
    do_op(1'b0, 3'b111, 32'd5, 32'd0, 0, "remu_by0");
    do_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    do_op(1'b0, 3'b000, 32'd3, 32'd5, 10, "backpressure");
    do_op(1'b0, 3'b101, 32'd1000, 32'd9, 0, "back_to_back");

    drive(1'b0, 3'b100, 32'h1234_5678, 32'h0000_0123, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst/ready", 32'(b32.o_ready), 32'd1);
    chk("midrst/valid", 32'(b32.o_valid), 32'd0);
    chk("midrst/o_1", b32.o_1, 32'd0);
    chk("midrst/zero", 32'(b32.o_zero), 32'd1);
    chk("midrst/neg", 32'(b32.o_neg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 3'b000, 32'd3, 32'd4, 0, "mul_after_rst");

    for (int i = 0; i < 40; i++)
      do_op(1'b0, 3'($urandom_range(7)), pick(), pick(), 0, "rand32");

    do_op(1'b1, 3'b000, 32'h7F, 32'h02, 0, "w8_mul");
    do_op(1'b1, 3'b100, 32'h80, 32'hFF, 0, "w8_div_ovf");
    do_op(1'b1, 3'b100, 32'h81, 32'h03, 0, "w8_div");
    do_op(1'b1, 3'b001, 32'h80, 32'h80, 2, "w8_mulh");
    for (int i = 0; i < 30; i++)
      do_op(1'b1, 3'($urandom_range(7)), pick(), pick(), 0, "rand8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
